sram_bus_ctrl: RTL and testbench

- Bus slave that turns single-word Bus_if reads and writes into timed asynchronous-SRAM cycles on the Sram_if pins.
- Sits directly downstream of the bus decoder, on the RAM_ADDRESS_PREFIX region.
- Holds bus stall while an access is in flight.
- Drives the 20-bit word-addressed, 32-bit SRAM chip with byte enables.

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_wait_timer.sv | 25 ++
 rtl/sram_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sram_bus_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the async-SRAM bus controller.
package sram_pkg;
  localparam int SRAM_ADDR_W       = 20;
  localparam int SRAM_RD_WAIT_DEF  = 2;
  localparam int SRAM_WR_PULSE_DEF = 2;
  localparam logic [3:0] SRAM_IDLE_BE_N = 4'hF;

  typedef logic [31:0]            Word_t;
  typedef logic [3:0]             ByteMask_t;
  typedef logic [SRAM_ADDR_W-1:0] SramAddr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD2, S_WR_SETUP, S_WR_PULSE, S_DONE
  } SramState_t;
endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter. done is high while the count is zero, so loading
// N-1 gives an N-cycle phase.
module sram_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign done = (cnt_q == '0);
endmodule

// File: rtl/sram_bus_ctrl.sv
// Bus slave driving timed async-SRAM read/write cycles.
// Optional SRAM_DUAL_READ_EN: each read also fetches the next word into bus_data_rd_2.
module sram_bus_ctrl
  import sram_pkg::*;
#(
  parameter int RD_WAIT  = SRAM_RD_WAIT_DEF,
  parameter int WR_PULSE = SRAM_WR_PULSE_DEF,
  parameter int ADDR_W   = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       bus_address,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [31:0]       bus_data_wr,
  input  logic [3:0]        bus_mask,
  output logic              bus_stall,
  output logic [31:0]       bus_data_rd,
  output logic [31:0]       bus_data_rd_2,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_data_i,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);
  localparam int CNT_W = 8;

  SramState_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  Word_t            data_q, data_d;
  ByteMask_t        mask_q, mask_d;
  logic             wr_q, wr_d;
  Word_t            rd_q, rd_d;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  logic             unused_addr;

  assign unused_addr = ^{bus_address[31:ADDR_W+2], bus_address[1:0]};

  sram_wait_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .load_val(tmr_val), .done(tmr_done)
  );

`ifdef SRAM_DUAL_READ_EN
  Word_t rd2_q, rd2_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef SRAM_DUAL_READ_EN
    rd2_d    = rd2_q;
`endif
    case (state_q)
      S_IDLE: begin
        // write wins over a simultaneous read
        if (bus_write) begin
          addr_d  = bus_address[ADDR_W+1:2];
          data_d  = bus_data_wr;
          mask_d  = bus_mask;
          wr_d    = 1'b1;
          state_d = S_WR_SETUP;
        end else if (bus_read) begin
          addr_d   = bus_address[ADDR_W+1:2];
          wr_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(RD_WAIT - 1);
          state_d  = S_RD;
        end
      end
      S_RD: if (tmr_done) begin
        rd_d = sram_data_i;
`ifdef SRAM_DUAL_READ_EN
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(RD_WAIT - 1);
        state_d  = S_RD2;
`else
        state_d  = S_DONE;
`endif
      end
`ifdef SRAM_DUAL_READ_EN
      S_RD2: if (tmr_done) begin
        rd2_d   = sram_data_i;
        state_d = S_DONE;
      end
`endif
      S_WR_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(WR_PULSE - 1);
        state_d  = S_WR_PULSE;
      end
      S_WR_PULSE: if (tmr_done) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end

`ifdef SRAM_DUAL_READ_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd2_q <= '0;
    else        rd2_q <= rd2_d;
  assign bus_data_rd_2 = rd2_q;
`else
  assign bus_data_rd_2 = '0;
`endif

  // Pin strobes decode straight from state so an async reset releases them at once.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_be_n    = SRAM_IDLE_BE_N;
    sram_data_oe = 1'b0;
    case (state_q)
      S_RD, S_RD2: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = 4'h0;
      end
      S_WR_SETUP: begin
        sram_ce_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~mask_q;
      end
      S_WR_PULSE: begin
        sram_ce_n    = 1'b0;
        sram_we_n    = 1'b0;
        sram_data_oe = 1'b1;
        sram_be_n    = ~mask_q;
      end
      S_DONE:  sram_data_oe = wr_q;
      default: ;
    endcase
  end

  assign sram_address = (state_q == S_RD2) ? addr_q + ADDR_W'(1) : addr_q;
  assign sram_data_o  = data_q;
  assign bus_data_rd  = rd_q;
  assign bus_stall    = (bus_read | bus_write) && (state_q != S_DONE);
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench: table vectors, reset sequence, random traffic vs a word-level memory model.
module tb_sram_bus_ctrl;
  localparam int RD_W = 2;
  localparam int WR_P = 2;
`ifdef SRAM_DUAL_READ_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam int RDS = DUAL ? 2*RD_W + 1 : RD_W + 1;
  localparam int WRS = WR_P + 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] bus_address = '0, bus_data_wr = '0;
  logic        bus_read = 1'b0, bus_write = 1'b0;
  logic [3:0]  bus_mask = '0;
  logic        bus_stall;
  logic [31:0] bus_data_rd, bus_data_rd_2, sram_data_o;
  logic [31:0] sram_data_i = '0;
  logic [19:0] sram_address;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  int n_vec = 0, n_err = 0, we_cnt = 0;

  sram_bus_ctrl #(.RD_WAIT(RD_W), .WR_PULSE(WR_P), .ADDR_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .bus_address(bus_address), .bus_read(bus_read),
    .bus_write(bus_write), .bus_data_wr(bus_data_wr), .bus_mask(bus_mask),
    .bus_stall(bus_stall), .bus_data_rd(bus_data_rd), .bus_data_rd_2(bus_data_rd_2),
    .sram_address(sram_address), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .sram_data_i(sram_data_i), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [31:0] chip [int unsigned];
  logic [31:0] refm [int unsigned];

  function automatic logic [31:0] init_w(int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [31:0] chip_rd(int unsigned w);
    return chip.exists(w) ? chip[w] : init_w(w);
  endfunction
  function automatic logic [31:0] ref_rd(int unsigned w);
    return refm.exists(w) ? refm[w] : init_w(w);
  endfunction
  function automatic void ref_wr(int unsigned w, logic [31:0] d, logic [3:0] m);
    logic [31:0] cur;
    cur = ref_rd(w);
    for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
    refm[w] = cur;
  endfunction
  function automatic int unsigned word_of(logic [31:0] a);
    return (a >> 2) & 32'hF_FFFF;
  endfunction

  // Chip model: writes on the active strobe, read data presented while oe is low.
  always @(negedge clk) begin
    logic [31:0] cur;
    if (rst_n && !sram_ce_n && !sram_we_n) begin
      cur = chip_rd(sram_address);
      for (int i = 0; i < 4; i++) if (!sram_be_n[i]) cur[8*i +: 8] = sram_data_o[8*i +: 8];
      chip[sram_address] = cur;
      we_cnt++;
    end
    sram_data_i = (!sram_ce_n && !sram_oe_n) ? chip_rd(sram_address) : 32'hBAD0BAD0;
    if (!sram_oe_n && !sram_we_n) begin
      n_err++; $display("FAIL oe_we_overlap: oe_n=%b we_n=%b want never both 0", sram_oe_n, sram_we_n);
    end
    if (sram_data_oe && !sram_oe_n) begin
      n_err++; $display("FAIL oe_contention: data_oe=%b oe_n=%b", sram_data_oe, sram_oe_n);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_acc(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int ncyc, output logic [19:0] a_s, output logic [3:0] be_s);
    @(negedge clk);
    we_cnt = 0;
    bus_read = rd; bus_write = wr; bus_address = a; bus_data_wr = d; bus_mask = m;
    #1;
    ncyc = 0; a_s = 'x; be_s = 'x;
    while (bus_stall && ncyc < 50) begin
      ncyc++;
      @(negedge clk); #1;
      if (ncyc == 1) begin a_s = sram_address; be_s = sram_be_n; end
    end
    bus_read = 1'b0; bus_write = 1'b0;
  endtask

  typedef struct {
    bit wr; bit rd; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;
    logic [31:0] exp_rd; logic [31:0] exp_rd2; int exp_cyc; logic [19:0] exp_a; logic [3:0] exp_be;
  } vec_t;

  function automatic vec_t mk(bit wr, bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] m,
                              logic [31:0] er, logic [31:0] er2);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.mask = m; v.exp_rd = er; v.exp_rd2 = er2;
    v.exp_cyc = wr ? WRS : RDS;
    v.exp_a   = 20'(word_of(a));
    v.exp_be  = wr ? ~m : 4'h0;
    return v;
  endfunction

  function automatic logic [31:0] nxt(int unsigned w);
    return DUAL ? init_w((w + 1) & 32'hF_FFFF) : 32'h0;
  endfunction

  initial begin
    vec_t tbl[10];
    int ncyc;
    logic [19:0] a_s;
    logic [3:0] be_s;
    logic [31:0] last_rd, last_rd2, merged, a, d, er2;
    int unsigned w;
    bit do_wr;

    merged = (init_w(8) & 32'hFF00FF00) | 32'h00220044;
    tbl[0] = mk(0, 1, 32'h0000_0010, 0, 0, 32'hDEADBEEF, nxt(4));
    tbl[1] = mk(1, 0, 32'h0000_0020, 32'h11223344, 4'b0101, 32'hDEADBEEF, 0);
    tbl[2] = mk(0, 1, 32'h0000_0020, 0, 0, merged, nxt(8));
    tbl[3] = mk(1, 0, 32'h0000_0040, 32'hCAFEBABE, 4'hF, merged, 0);
    tbl[4] = mk(0, 1, 32'h0000_0040, 0, 0, 32'hCAFEBABE, nxt(16));
    tbl[5] = mk(1, 1, 32'h0000_0080, 32'h12345678, 4'hF, 32'hCAFEBABE, 0);
    tbl[6] = mk(0, 1, 32'h0000_0080, 0, 0, 32'h12345678, nxt(32));
    tbl[7] = mk(1, 0, 32'h0000_0010, 32'hFFFFFFFF, 4'h0, 32'h12345678, 0);
    tbl[8] = mk(0, 1, 32'h8000_0013, 0, 0, 32'hDEADBEEF, nxt(4));
    tbl[9] = mk(0, 1, 32'h003F_FFFC, 0, 0, init_w(20'hFFFFF), nxt(20'hFFFFF));
    chip[4] = 32'hDEADBEEF;
    refm[4] = 32'hDEADBEEF;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
    chk("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    chk("rst_misc", {bus_stall, 11'h0, sram_address}, 32'h0);
    chk("rst_data", bus_data_rd | bus_data_rd_2 | sram_data_o, 32'h0);
    rst_n = 1'b1;

    // async reset in the middle of a write pulse
    @(negedge clk);
    bus_write = 1'b1; bus_address = 32'h0000_0300; bus_data_wr = 32'hA5A5A5A5; bus_mask = 4'hF;
    ncyc = 0;
    while (sram_we_n && ncyc < 20) begin @(negedge clk); ncyc++; end
    chk("wr_pulse_seen", {31'h0, sram_we_n}, 32'h0);
    #2;
    rst_n = 1'b0; bus_write = 1'b0;
    #1;
    chk("midrst_ctrl", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
    chk("midrst_stall", {31'h0, bus_stall}, 32'h0);
    chk("midrst_addr", {12'h0, sram_address}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      last_rd2 = bus_data_rd_2;
      do_acc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mask, ncyc, a_s, be_s);
      chk($sformatf("v%0d_stall_cycles", i), ncyc, tbl[i].exp_cyc);
      chk($sformatf("v%0d_addr", i), {12'h0, a_s}, {12'h0, tbl[i].exp_a});
      chk($sformatf("v%0d_be_n", i), {28'h0, be_s}, {28'h0, tbl[i].exp_be});
      chk($sformatf("v%0d_data_rd", i), bus_data_rd, tbl[i].exp_rd);
      if (tbl[i].wr) begin
        chk($sformatf("v%0d_we_cycles", i), we_cnt, WR_P);
        chk($sformatf("v%0d_data_rd_2_hold", i), bus_data_rd_2, last_rd2);
        ref_wr(word_of(tbl[i].addr), tbl[i].wdata, tbl[i].mask);
      end else begin
        chk($sformatf("v%0d_data_rd_2", i), bus_data_rd_2, tbl[i].exp_rd2);
        chk($sformatf("v%0d_we_cycles", i), we_cnt, 0);
      end
    end

    // random traffic against the word-level reference model
    last_rd  = bus_data_rd;
    last_rd2 = bus_data_rd_2;
    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 9) == 0) ? 32'hF_FFFF : $urandom_range(0, 15);
      a = {$urandom_range(0, 1023) & 32'h3FF, 20'(w), 2'($urandom_range(0, 3))};
      d = $urandom;
      do_wr = $urandom_range(0, 1);
      if (do_wr) begin
        logic [3:0] m;
        m = 4'($urandom_range(0, 15));
        do_acc(1'b0, 1'b1, a, d, m, ncyc, a_s, be_s);
        chk("rnd_wr_stall", ncyc, WRS);
        chk("rnd_wr_hold", bus_data_rd, last_rd);
        ref_wr(w, d, m);
      end else begin
        do_acc(1'b1, 1'b0, a, 0, 0, ncyc, a_s, be_s);
        er2 = DUAL ? ref_rd((w + 1) & 32'hF_FFFF) : 32'h0;
        chk("rnd_rd_stall", ncyc, RDS);
        chk("rnd_rd_data", bus_data_rd, ref_rd(w));
        chk("rnd_rd_data2", bus_data_rd_2, er2);
        last_rd = ref_rd(w);
        last_rd2 = er2;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
